// File: rtl/seq_mult_handshake.sv
// -----------------------------------------------------------------------------
// seq_mult_handshake
//   Iterative shift-add multiplier that consumes one multiplier bit per clock.
//   Signed or unsigned mode is chosen for each operation. Valid/ready
//   handshakes on both sides let it sit between a producer and a consumer
//   that may stall. A finished product is held until the consumer takes it.
//
//   The core always works on unsigned magnitudes. The sign of a signed
//   product is applied once, on the cycle the result is written to out.
//
// Parameters
//   WIDTH      operand width (2..32); the product is 2*WIDTH bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode are valid this cycle
//   in_ready   block can accept operands (high only while idle)
//   ina        multiplicand
//   inb        multiplier
//   is_signed  1: ina/inb are two's complement, 0: unsigned
//   out_valid  out holds a completed product
//   out_ready  consumer takes out this cycle
//   out        product, 2*WIDTH bits; keeps its value until the next completion
//   busy       iteration in progress
// -----------------------------------------------------------------------------
module seq_mult_handshake #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic                 neg;

    // Accumulator value after this cycle's conditional add.
    logic [2*WIDTH-1:0]   acc_sum;

    // The magnitude of the most negative value, -2^(WIDTH-1), wraps to the
    // bit pattern 2^(WIDTH-1). Read as unsigned, that is exactly the right
    // magnitude, so no extra bit is needed.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic signed [WIDTH-1:0] v,
        input logic                    as_signed
    );
        logic signed [WIDTH-1:0] n;
        n = -v;
        if (as_signed && v[WIDTH-1])
            return n;
        else
            return v;
    endfunction

    // Apply the result sign to the unsigned accumulator.
    function automatic logic [2*WIDTH-1:0] apply_sign(
        input logic [2*WIDTH-1:0] mag,
        input logic               negate
    );
        logic signed [2*WIDTH-1:0] s;
        s = mag;
        if (negate)
            return -s;
        else
            return s;
    endfunction

    always_comb begin
        acc_sum = acc;
        if (mplier[0])
            acc_sum = acc + mcand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                // Accept operands; the sign is resolved now, and the core
                // then iterates on magnitudes only.
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= {{WIDTH{1'b0}}, magnitude(ina, is_signed)};
                        mplier   <= magnitude(inb, is_signed);
                        neg      <= is_signed & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                        acc      <= '0;
                        count    <= CW'(WIDTH);
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                // One multiplier bit per cycle. There is no early exit, so
                // latency does not depend on the data.
                BUSY: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        out       <= apply_sign(acc_sum, neg);
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end

                // Hold the result until the consumer takes it.
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
